serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first WIDTH-bit subtractor computing a - b.
- Companion to the combinational one-bit adder; it runs the arithmetic the other way, as a difference/borrow stage.
- One full-subtractor cell is reused every cycle with a registered borrow. A start/busy/done handshake frames each operation.
- Used where area matters more than latency, e.g. serial datapaths and small control counters.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when busy=0
- a  input  WIDTH  minuend; captured on an accepted start
- b  input  WIDTH  subtrahend; captured on an accepted start
- busy  output  1  high while the subtraction is in progress
- done  output  1  one-cycle pulse when diff/borrow_out become valid
- diff  output  WIDTH  result (a - b) mod 2^WIDTH; held until the next accepted start
- borrow_out  output  1  final borrow; 1 if and only if a < b (unsigned)
- dbit  output  1  difference bit produced in the current RUN cycle (serial monitor)
- dbit_valid  output  1  high in each RUN cycle that dbit is meaningful

Behaviour:
- Reset: synchronous, active-high; takes priority over everything else. At the edge where rst=1:
  - FSM goes to IDLE.
  - busy, done, diff, borrow_out, dbit and dbit_valid all go to 0.
  - Internal shift registers, bit counter and borrow flop are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0. If start=1 at an edge, capture a and b into shift registers, clear the borrow flop and bit counter, and go to RUN.
  - RUN: busy=1, dbit_valid=1. Each edge processes bit i = counter, LSB first:
    - x = a_sh[0], y = b_sh[0], bin = borrow flop
    - d = x ^ y ^ bin
    - bout = (~x & y) | (~(x ^ y) & bin)
    - d shifts into the MSB of the result register (after WIDTH shifts, diff[i] = d of bit i)
    - borrow flop <= bout; a_sh and b_sh shift right by 1; counter increments
    - After the edge processing bit WIDTH-1, go to DONE.
  - DONE: lasts exactly one cycle.
    - done=1, busy=0.
    - diff and borrow_out are valid (borrow_out = last bout).
    - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accept).
- dbit is combinational from the current cell inputs in RUN. dbit=0 when dbit_valid=0.
- diff and borrow_out update only on the DONE transition. They do not change during RUN; the previous result stays visible until the new DONE.
- Latency: start accepted at edge k, busy=1 from cycle k+1 through k+WIDTH, done=1 in cycle k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored, and a/b changes during RUN have no effect.
- Reset asserted mid-RUN aborts the operation: no done pulse, and diff/borrow_out clear to 0.
- Arithmetic: unsigned. diff = (a - b) mod 2^WIDTH, borrow_out = (a < b). Equivalently {borrow_out, diff} = a + ~b + 1 with the carry inverted.
- Properties the SVA module must assert:
  - done is a single-cycle pulse
  - !(busy && done)
  - dbit_valid == busy
  - busy stays high for exactly WIDTH consecutive cycles after an accepted start
  - on done: diff == (a_cap - b_cap) mod 2^WIDTH and borrow_out == (a_cap < b_cap)
  - per RUN cycle: dbit == x ^ y ^ bin

Test Plan:
- WIDTH=8, a=5, b=3, start one cycle -> busy for 8 cycles; dbit sequence LSB-first 0,1,0,0,0,0,0,0; done in cycle 9; diff=0x02, borrow_out=0.
- a=3, b=5 -> diff=0xFE, borrow_out=1; a=0x00, b=0x00 -> diff=0x00, borrow_out=0.
- a=0x00, b=0x01 -> diff=0xFF, borrow_out=1, borrow propagating through all 8 bits; then a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0.
- start pulsed with a=9, b=4, then start re-pulsed with a=1, b=2 during RUN -> second request ignored; diff=0x05, borrow_out=0, exactly one done.
- start asserted in the DONE cycle with a=0x80, b=0x7F -> new RUN begins the next cycle with no IDLE gap; second done yields diff=0x01, borrow_out=0.
- rst=1 at the 4th RUN cycle of a=200, b=100 -> next cycle busy=0, done never pulses, diff=0, borrow_out=0; a fresh start afterwards completes normally with diff=100.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell reused each cycle.
// A start/busy/done handshake frames each WIDTH-bit operation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             dbit,
    output logic             dbit_valid
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic x;
    logic y;
    logic d;
    logic bout;
    logic last;

    assign x    = a_sh[0];
    assign y    = b_sh[0];
    assign d    = x ^ y ^ brw;
    assign bout = (~x & y) | (~(x ^ y) & brw);
    assign last = (cnt == CW'(WIDTH - 1));

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign dbit_valid = busy;
    assign dbit       = busy & d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    // DONE accepts start too, so back-to-back ops need no idle gap
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d, res[WIDTH-1:1]};
                    brw  <= bout;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        diff       <= {d, res[WIDTH-1:1]};
                        borrow_out <= bout;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Table vectors, hand sequences for corner cases, and random ops vs. a model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         dbit;
    logic         dbit_valid;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] last_diff;
    logic         last_bo;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .dbit       (dbit),
        .dbit_valid (dbit_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ediff;
        logic         ebo;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned dx;
        dx = (int'(x) - int'(y)) & ((1 << W) - 1);
        return {(x < y), dx[W-1:0]};
    endfunction

    // Called at a negedge: present a new request for the next rising edge
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb);
        start = 1'b1;
        a     = va;
        b     = vb;
    endtask

    // Walks the RUN cycles and the DONE cycle, checking every serial bit
    task automatic finish_op(input logic [W-1:0] ediff, input logic ebo);
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        for (int i = 0; i < W; i++) begin
            chk("run_busy", int'(busy), 1);
            chk("run_done_low", int'(done), 0);
            chk("run_dbit", int'(dbit), int'(ediff[i]));
            chk("run_diff_held", int'(diff), int'(last_diff));
            chk("run_bo_held", int'(borrow_out), int'(last_bo));
            if (i < W - 1) @(negedge clk);
        end
        @(negedge clk);
        chk("done_pulse", int'(done), 1);
        chk("done_busy_low", int'(busy), 0);
        chk("done_dvalid_low", int'(dbit_valid), 0);
        chk("done_diff", int'(diff), int'(ediff));
        chk("done_borrow", int'(borrow_out), int'(ebo));
        last_diff = ediff;
        last_bo   = ebo;
    endtask

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ediff, input logic ebo);
        launch(va, vb);
        finish_op(ediff, ebo);
    endtask

    // Continuous monitors, sampled just after each rising edge
    int run_len = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            run_len   = 0;
            prev_done = 1'b0;
        end else begin
            chk("mon_busy_and_done", int'(busy && done), 0);
            chk("mon_dvalid_eq_busy", int'(dbit_valid), int'(busy));
            if (prev_done) chk("mon_done_single", int'(done), 0);
            if (busy) begin
                run_len++;
            end else begin
                if (run_len != 0) chk("mon_busy_len", run_len, W);
                run_len = 0;
            end
            if (done) done_cnt++;
            prev_done = done;
        end
    end

    vec_t vecs[7];
    int   d0;
    logic [W:0] r;

    initial begin
        vecs[0] = '{8'd5,   8'd3,   8'h02, 1'b0};
        vecs[1] = '{8'd3,   8'd5,   8'hFE, 1'b1};
        vecs[2] = '{8'h00,  8'h00,  8'h00, 1'b0};
        vecs[3] = '{8'h00,  8'h01,  8'hFF, 1'b1};
        vecs[4] = '{8'hFF,  8'h01,  8'hFE, 1'b0};
        vecs[5] = '{8'd200, 8'd100, 8'd100, 1'b0};
        vecs[6] = '{8'h80,  8'h7F,  8'h01, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        last_diff = '0;
        last_bo   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_borrow", int'(borrow_out), 0);
        chk("rst_dbit", int'(dbit), 0);
        chk("rst_dvalid", int'(dbit_valid), 0);

        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            run_op(vecs[k].va, vecs[k].vb, vecs[k].ediff, vecs[k].ebo);
            @(negedge clk);
            chk("idle_after_done", int'(busy | done), 0);
        end

        // Start re-pulsed mid-run must be ignored
        d0 = done_cnt;
        launch(8'd9, 8'd4);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        launch(8'd1, 8'd2);
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("ignored_start_diff", int'(diff), 5);
        chk("ignored_start_borrow", int'(borrow_out), 0);
        chk("ignored_start_one_done", done_cnt - d0, 1);
        chk("ignored_start_idle", int'(busy), 0);
        last_diff = 8'd5;
        last_bo   = 1'b0;

        // Back-to-back: start held during the DONE cycle
        run_op(8'd20, 8'd7, 8'd13, 1'b0);
        launch(8'h80, 8'h7F);
        finish_op(8'h01, 1'b0);
        @(negedge clk);

        // Reset in the 4th RUN cycle aborts without a done pulse
        d0 = done_cnt;
        launch(8'd200, 8'd100);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_borrow", int'(borrow_out), 0);
        repeat (W + 2) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        last_diff = '0;
        last_bo   = 1'b0;
        run_op(8'd200, 8'd100, 8'd100, 1'b0);
        @(negedge clk);

        // Random operations against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            if (k % 8 == 0) rb = ra;
            r = ref_sub(ra, rb);
            run_op(ra, rb, r[W-1:0], r[W]);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
